// File: rtl/cache_bank_interco.sv
// rtl/cache_bank_interco.sv - core-to-cache-bank request/response interconnect with runtime bank-offset reconfiguration
// Optional feature macro: CACHE_BANK_INTERCO_PERF_EN (per-bank conflict counters)

package cache_bank_interco_pkg;
   typedef struct packed {
      logic [7:0]  core_id;
   } tcdm_user_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] data;
      logic [3:0]  strb;
      tcdm_user_t  user;
   } tcdm_req_chan_t;

   typedef struct packed {
      logic [31:0] data;
      tcdm_user_t  user;
   } tcdm_rsp_chan_t;

   typedef struct packed {
      tcdm_req_chan_t q;
      logic           q_valid;
   } tcdm_req_t;

   typedef struct packed {
      tcdm_rsp_chan_t p;
      logic           p_valid;
      logic           q_ready;
   } tcdm_rsp_t;
endpackage

module cache_bank_interco #(
   parameter int unsigned NumCore        = 4,
   parameter int unsigned NumCache       = 4,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned ReqFifoDepth   = 2,
   parameter int unsigned MaxOutstanding = 4,
   parameter type tcdm_req_t      = cache_bank_interco_pkg::tcdm_req_t,
   parameter type tcdm_rsp_t      = cache_bank_interco_pkg::tcdm_rsp_t,
   parameter type tcdm_req_chan_t = cache_bank_interco_pkg::tcdm_req_chan_t,
   parameter type tcdm_rsp_chan_t = cache_bank_interco_pkg::tcdm_rsp_chan_t
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [$clog2(AddrWidth)-1:0] cfg_offset_i,
   input  logic                         cfg_valid_i,
   output logic                         cfg_ready_o,
   output logic [$clog2(AddrWidth)-1:0] active_offset_o,
   input  tcdm_req_t                    core_req_i      [NumCore],
   output tcdm_rsp_t                    core_rsp_o      [NumCore],
   input  logic [NumCore-1:0]           core_rsp_ready_i,
   output tcdm_req_t                    mem_req_o       [NumCache],
   input  tcdm_rsp_t                    mem_rsp_i       [NumCache],
   output logic [NumCache-1:0]          mem_rsp_ready_o,
   output logic [31:0]                  perf_conflict_o [NumCache]
);

   localparam int unsigned OffW  = $clog2(AddrWidth);
   localparam int unsigned BankW = $clog2(NumCache);
   localparam int unsigned CoreW = $clog2(NumCore);
   localparam int unsigned PtrW  = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
   localparam int unsigned CntW  = $clog2(ReqFifoDepth + 1);
   localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);

   typedef enum logic [1:0] {RUN, DRAIN, UPDATE} state_e;

   state_e          r_state;
   logic            r_cfg_ready;
   logic [OffW-1:0] r_offset;

   tcdm_req_chan_t  r_fifo_mem [NumCore][ReqFifoDepth];
   logic [PtrW-1:0] r_rd_ptr   [NumCore];
   logic [PtrW-1:0] r_wr_ptr   [NumCore];
   logic [CntW-1:0] r_cnt      [NumCore];
   logic [OutW-1:0] r_out      [NumCore];
   logic [CoreW-1:0] r_req_ptr [NumCache];
   logic [BankW-1:0] r_rsp_ptr [NumCore];

   tcdm_req_chan_t  w_head     [NumCore];
   tcdm_req_chan_t  w_fwd      [NumCore];
   logic [BankW-1:0] w_head_bank [NumCore];
   logic [NumCore-1:0] w_elig;
   logic [NumCore-1:0] w_push;
   logic [NumCore-1:0] w_pop;
   logic [NumCore-1:0] w_q_ready;
   logic [CntW-1:0] w_cnt_next [NumCore];
   logic [OutW-1:0] w_out_next [NumCore];
   logic            w_idle_next;

   logic [NumCore-1:0]  w_breq      [NumCache];
   logic [NumCache-1:0] w_bank_valid;
   logic [NumCache-1:0] w_bank_acc;
   logic [CoreW-1:0]    w_bank_gnt  [NumCache];

   logic [NumCache-1:0] w_routable;
   logic [CoreW-1:0]    w_rsp_core  [NumCache];
   logic [NumCache-1:0] w_rreq      [NumCore];
   logic [NumCore-1:0]  w_rsp_valid;
   logic [NumCore-1:0]  w_rsp_hs;
   logic [BankW-1:0]    w_rsp_gnt   [NumCore];
   tcdm_rsp_chan_t      w_rsp_p     [NumCore];

   // Bank index is the BankW-bit field starting at the active offset.
   function automatic logic [BankW-1:0] f_bank(input logic [AddrWidth-1:0] a,
                                               input logic [OffW-1:0] off);
      logic [AddrWidth-1:0] s;
      s = a >> off;
      return s[BankW-1:0];
   endfunction

   // Remove the bank field: upper bits slide down over it, top bits fill with zero.
   function automatic logic [AddrWidth-1:0] f_compact(input logic [AddrWidth-1:0] a,
                                                      input logic [OffW-1:0] off);
      logic [AddrWidth-1:0] lo_mask;
      lo_mask = ~({AddrWidth{1'b1}} << off);
      return (a & lo_mask) | ((a >> (32'(off) + BankW)) << off);
   endfunction

   // Core side: FIFO heads, their target bank, eligibility and acceptance.
   always_comb begin
      for (int c = 0; c < NumCore; c++) begin
         w_head[c]      = r_fifo_mem[c][r_rd_ptr[c]];
         w_head_bank[c] = f_bank(w_head[c].addr[AddrWidth-1:0], r_offset);
         w_elig[c]      = (r_cnt[c] != '0) && (r_out[c] < OutW'(MaxOutstanding));
         w_q_ready[c]   = (r_cnt[c] != CntW'(ReqFifoDepth)) && (r_state == RUN) && !rst_i;
         w_push[c]      = core_req_i[c].q_valid && w_q_ready[c];
         w_fwd[c]       = w_head[c];
         w_fwd[c].addr  = '0;
         w_fwd[c].addr[AddrWidth-1:0] = f_compact(w_head[c].addr[AddrWidth-1:0], r_offset);
         w_fwd[c].user.core_id = '0;
         w_fwd[c].user.core_id[CoreW-1:0] = CoreW'(c);
      end
   end

   // Per-bank round-robin: scan in reverse priority so the pointer's core wins last.
   always_comb begin
      for (int b = 0; b < NumCache; b++) begin
         for (int c = 0; c < NumCore; c++) begin
            w_breq[b][c] = w_elig[c] && (w_head_bank[c] == BankW'(b));
         end
         w_bank_valid[b] = 1'b0;
         w_bank_gnt[b]   = '0;
         for (int i = NumCore - 1; i >= 0; i--) begin
            if (w_breq[b][r_req_ptr[b] + CoreW'(i)]) begin
               w_bank_valid[b] = 1'b1;
               w_bank_gnt[b]   = r_req_ptr[b] + CoreW'(i);
            end
         end
         w_bank_acc[b] = w_bank_valid[b] && mem_rsp_i[b].q_ready && !rst_i;
      end
   end

   // Pops and next-cycle occupancy; DRAIN looks ahead so it exits on the last handshake.
   always_comb begin
      w_idle_next = 1'b1;
      for (int c = 0; c < NumCore; c++) begin
         w_pop[c] = 1'b0;
         for (int b = 0; b < NumCache; b++) begin
            if (w_bank_acc[b] && (w_bank_gnt[b] == CoreW'(c))) w_pop[c] = 1'b1;
         end
         w_cnt_next[c] = r_cnt[c] + CntW'(w_push[c]) - CntW'(w_pop[c]);
         w_out_next[c] = r_out[c] + OutW'(w_pop[c]) - OutW'(w_rsp_hs[c]);
         if ((w_cnt_next[c] != '0) || (w_out_next[c] != '0)) w_idle_next = 1'b0;
      end
   end

   // Response routing: responses for cores with nothing outstanding are swallowed.
   always_comb begin
      for (int b = 0; b < NumCache; b++) begin
         w_rsp_core[b] = mem_rsp_i[b].p.user.core_id[CoreW-1:0];
         w_routable[b] = mem_rsp_i[b].p_valid
                         && (32'(mem_rsp_i[b].p.user.core_id) < NumCore)
                         && (r_out[w_rsp_core[b]] != '0);
      end
      for (int c = 0; c < NumCore; c++) begin
         for (int b = 0; b < NumCache; b++) begin
            w_rreq[c][b] = w_routable[b] && (w_rsp_core[b] == CoreW'(c));
         end
         w_rsp_valid[c] = 1'b0;
         w_rsp_gnt[c]   = '0;
         for (int i = NumCache - 1; i >= 0; i--) begin
            if (w_rreq[c][r_rsp_ptr[c] + BankW'(i)]) begin
               w_rsp_valid[c] = 1'b1;
               w_rsp_gnt[c]   = r_rsp_ptr[c] + BankW'(i);
            end
         end
         w_rsp_p[c]  = mem_rsp_i[w_rsp_gnt[c]].p;
         w_rsp_hs[c] = w_rsp_valid[c] && core_rsp_ready_i[c] && !rst_i;
      end
   end

   // Drive core and bank ports; everything visible is masked while in reset.
   always_comb begin
      for (int c = 0; c < NumCore; c++) begin
         core_rsp_o[c]         = '0;
         core_rsp_o[c].p       = w_rsp_p[c];
         core_rsp_o[c].p_valid = w_rsp_valid[c] && !rst_i;
         core_rsp_o[c].q_ready = w_q_ready[c];
      end
      for (int b = 0; b < NumCache; b++) begin
         mem_req_o[b]         = '0;
         mem_req_o[b].q       = w_fwd[w_bank_gnt[b]];
         mem_req_o[b].q_valid = w_bank_valid[b] && !rst_i;
         mem_rsp_ready_o[b]   = rst_i || !w_routable[b]
                                || ((w_rsp_gnt[w_rsp_core[b]] == BankW'(b))
                                    && core_rsp_ready_i[w_rsp_core[b]]);
      end
   end

   // FIFO storage; payload needs no reset since occupancy is tracked separately.
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NumCore; c++) begin
         if (w_push[c]) r_fifo_mem[c][r_wr_ptr[c]] <= core_req_i[c].q;
      end
   end

   // FIFO pointers, occupancy, outstanding counts and arbiter pointers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < NumCore; c++) begin
            r_rd_ptr[c]  <= '0;
            r_wr_ptr[c]  <= '0;
            r_cnt[c]     <= '0;
            r_out[c]     <= '0;
            r_rsp_ptr[c] <= '0;
         end
         for (int b = 0; b < NumCache; b++) r_req_ptr[b] <= '0;
      end else begin
         for (int c = 0; c < NumCore; c++) begin
            if (w_push[c])
               r_wr_ptr[c] <= (r_wr_ptr[c] == PtrW'(ReqFifoDepth - 1)) ? '0 : r_wr_ptr[c] + PtrW'(1);
            if (w_pop[c])
               r_rd_ptr[c] <= (r_rd_ptr[c] == PtrW'(ReqFifoDepth - 1)) ? '0 : r_rd_ptr[c] + PtrW'(1);
            r_cnt[c] <= w_cnt_next[c];
            r_out[c] <= w_out_next[c];
            if (w_rsp_hs[c]) r_rsp_ptr[c] <= w_rsp_gnt[c] + BankW'(1);
         end
         for (int b = 0; b < NumCache; b++) begin
            if (w_bank_acc[b]) r_req_ptr[b] <= w_bank_gnt[b] + CoreW'(1);
         end
      end
   end

   // Reconfiguration FSM: stop intake, wait for quiescence, swap offset, pulse ready.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= RUN;
         r_cfg_ready <= 1'b0;
         r_offset    <= OffW'(6);
      end else begin
         case (r_state)
            RUN: begin
               r_cfg_ready <= 1'b0;
               if (cfg_valid_i) r_state <= DRAIN;
            end
            DRAIN: begin
               if (w_idle_next) begin
                  r_state     <= UPDATE;
                  r_cfg_ready <= 1'b1;
               end
            end
            UPDATE: begin
               r_offset    <= cfg_offset_i;
               r_cfg_ready <= 1'b0;
               r_state     <= RUN;
            end
            default: begin
               r_state     <= RUN;
               r_cfg_ready <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready_o     = r_cfg_ready;
   assign active_offset_o = r_offset;

`ifdef CACHE_BANK_INTERCO_PERF_EN
   logic [31:0] r_conflict [NumCache];

   // Saturating count of cycles with two or more eligible heads on a bank.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int b = 0; b < NumCache; b++) r_conflict[b] <= '0;
      end else begin
         for (int b = 0; b < NumCache; b++) begin
            if (($countones(w_breq[b]) > 1) && (r_conflict[b] != '1))
               r_conflict[b] <= r_conflict[b] + 32'd1;
         end
      end
   end

   // Expose the counters.
   always_comb begin
      for (int b = 0; b < NumCache; b++) perf_conflict_o[b] = r_conflict[b];
   end
`else
   // Counters absent: constant zero.
   always_comb begin
      for (int b = 0; b < NumCache; b++) perf_conflict_o[b] = '0;
   end
`endif

endmodule

// File: tb/tb_cache_bank_interco.sv
// tb/tb_cache_bank_interco.sv - directed self-checking bench for cache_bank_interco
module tb_cache_bank_interco;
   import cache_bank_interco_pkg::*;

`ifdef CACHE_BANK_INTERCO_PERF_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  cfg_offset;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [4:0]  active_offset;
   tcdm_req_t   core_req [4];
   tcdm_rsp_t   core_rsp [4];
   logic [3:0]  core_rsp_ready;
   tcdm_req_t   mem_req  [4];
   tcdm_rsp_t   mem_rsp  [4];
   logic [3:0]  mem_rsp_ready;
   logic [31:0] perf     [4];

   int n_checks = 0;
   int n_errors = 0;
   int acc;
   int exp_gnt [5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   cache_bank_interco #(
      .NumCore(4), .NumCache(4), .AddrWidth(32), .ReqFifoDepth(2), .MaxOutstanding(4)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .cfg_offset_i     (cfg_offset),
      .cfg_valid_i      (cfg_valid),
      .cfg_ready_o      (cfg_ready),
      .active_offset_o  (active_offset),
      .core_req_i       (core_req),
      .core_rsp_o       (core_rsp),
      .core_rsp_ready_i (core_rsp_ready),
      .mem_req_o        (mem_req),
      .mem_rsp_i        (mem_rsp),
      .mem_rsp_ready_o  (mem_rsp_ready),
      .perf_conflict_o  (perf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 4; i++) begin
         core_req[i]         = '0;
         mem_rsp[i]          = '0;
         mem_rsp[i].q_ready  = 1'b1;
      end
      core_rsp_ready = 4'hF;
      cfg_valid      = 1'b0;
      cfg_offset     = 5'd6;
   endtask

   task automatic drive_core(input int c, input logic [31:0] addr, input logic [31:0] data);
      core_req[c]         = '0;
      core_req[c].q_valid = 1'b1;
      core_req[c].q.addr  = addr;
      core_req[c].q.data  = data;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   function automatic logic any_qv();
      logic v;
      v = 1'b0;
      for (int b = 0; b < 4; b++) v = v | mem_req[b].q_valid;
      return v;
   endfunction

   initial begin
      idle_inputs();
      cyc();
      #2;
      check("rst_qvalid", 64'(any_qv()), 64'd0);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
      cyc();
      rst = 1'b0;
      #2;
      check("post_rst_offset", 64'(active_offset), 64'd6);
      check("post_rst_qvalid", 64'(any_qv()), 64'd0);
      check("post_rst_pvalid", 64'(core_rsp[0].p_valid), 64'd0);
      check("post_rst_cfg_ready", 64'(cfg_ready), 64'd0);
      check("post_rst_qready", 64'(core_rsp[0].q_ready), 64'd1);
      check("post_rst_perf", 64'(perf[2]), 64'd0);

      // single read core0 -> bank 1, response straight back
      drive_core(0, 32'h0000_0040, 32'h11);
      #2;
      check("lat_zero_qvalid", 64'(mem_req[1].q_valid), 64'd0);
      cyc();
      core_req[0].q_valid = 1'b0;
      #2;
      check("b1_qvalid", 64'(mem_req[1].q_valid), 64'd1);
      check("b1_addr", 64'(mem_req[1].q.addr), 64'h0);
      check("b1_core_id", 64'(mem_req[1].q.user.core_id), 64'd0);
      check("b0_qvalid", 64'(mem_req[0].q_valid), 64'd0);
      cyc();
      mem_rsp[1].p_valid          = 1'b1;
      mem_rsp[1].p.data           = 32'hABCD;
      mem_rsp[1].p.user.core_id   = 8'd0;
      #2;
      check("rsp_pvalid", 64'(core_rsp[0].p_valid), 64'd1);
      check("rsp_data", 64'(core_rsp[0].p.data), 64'hABCD);
      check("rsp_ready", 64'(mem_rsp_ready[1]), 64'd1);
      check("rsp_other_core", 64'(core_rsp[1].p_valid), 64'd0);
      cyc();
      mem_rsp[1].p_valid = 1'b0;

      // all cores hammer bank 2: round-robin order and conflict counter
      do_reset();
      for (int k = 0; k < 4; k++) drive_core(k, 32'h0000_0080, 32'(k));
      cyc();
      for (int k = 0; k < 5; k++) begin
         #2;
         check("rr_qvalid", 64'(mem_req[2].q_valid), 64'd1);
         check("rr_grant", 64'(mem_req[2].q.user.core_id), 64'(exp_gnt[k]));
         check("rr_data", 64'(mem_req[2].q.data), 64'(exp_gnt[k]));
         check("rr_perf", 64'(perf[2]), PerfEn ? 64'(k) : 64'd0);
         cyc();
      end
      check("rr_perf_b0", 64'(perf[0]), 64'd0);

      // bank 0 stalled, core1 FIFO fills after two accepts
      do_reset();
      mem_rsp[0].q_ready = 1'b0;
      drive_core(1, 32'h0, 32'h5);
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         #2;
         if (core_rsp[1].q_ready) acc++;
         cyc();
      end
      #2;
      check("full_accepts", 64'(acc), 64'd2);
      check("full_qready", 64'(core_rsp[1].q_ready), 64'd0);
      check("full_head_valid", 64'(mem_req[0].q_valid), 64'd1);
      check("full_head_core", 64'(mem_req[0].q.user.core_id), 64'd1);

      // reconfiguration with three outstanding requests
      do_reset();
      drive_core(0, 32'h0000_00C0, 32'h1);
      cyc();
      cyc();
      cyc();
      core_req[0].q_valid = 1'b0;
      cyc();
      cyc();
      #2;
      check("drain_fifo_empty", 64'(mem_req[3].q_valid), 64'd0);
      cfg_valid  = 1'b1;
      cfg_offset = 5'd12;
      cyc();
      #2;
      check("drain_qready0", 64'(core_rsp[0].q_ready), 64'd0);
      cyc();
      #2;
      check("drain_qready1", 64'(core_rsp[0].q_ready), 64'd0);
      check("drain_cfg_ready", 64'(cfg_ready), 64'd0);
      for (int r = 0; r < 3; r++) begin
         mem_rsp[3].p_valid        = 1'b1;
         mem_rsp[3].p.data         = 32'(r);
         mem_rsp[3].p.user.core_id = 8'd0;
         #2;
         check("drain_rsp_pvalid", 64'(core_rsp[0].p_valid), 64'd1);
         check("drain_rsp_cfg_ready", 64'(cfg_ready), 64'd0);
         cyc();
      end
      mem_rsp[3].p_valid = 1'b0;
      #2;
      check("update_cfg_ready", 64'(cfg_ready), 64'd1);
      check("update_qready", 64'(core_rsp[0].q_ready), 64'd0);
      cyc();
      cfg_valid = 1'b0;
      #2;
      check("run_cfg_ready", 64'(cfg_ready), 64'd0);
      check("run_offset", 64'(active_offset), 64'd12);
      check("run_qready", 64'(core_rsp[0].q_ready), 64'd1);
      drive_core(0, 32'h0000_1000, 32'h7);
      cyc();
      core_req[0].q_valid = 1'b0;
      #2;
      check("off12_b1_qvalid", 64'(mem_req[1].q_valid), 64'd1);
      check("off12_b1_addr", 64'(mem_req[1].q.addr), 64'h0);
      check("off12_b1_data", 64'(mem_req[1].q.data), 64'h7);
      cyc();

      // reset while requests are queued
      for (int b = 0; b < 4; b++) mem_rsp[b].q_ready = 1'b0;
      drive_core(0, 32'h0, 32'h21);
      drive_core(2, 32'h0, 32'h22);
      cyc();
      core_req[0].q_valid = 1'b0;
      core_req[2].q_valid = 1'b0;
      #2;
      check("queued_qvalid", 64'(mem_req[0].q_valid), 64'd1);
      rst = 1'b1;
      #2;
      check("in_rst_qvalid", 64'(mem_req[0].q_valid), 64'd0);
      cyc();
      rst = 1'b0;
      for (int b = 0; b < 4; b++) mem_rsp[b].q_ready = 1'b1;
      #2;
      check("after_rst_qvalid", 64'(any_qv()), 64'd0);
      check("after_rst_offset", 64'(active_offset), 64'd6);
      check("after_rst_cfg_ready", 64'(cfg_ready), 64'd0);
      cyc();
      #2;
      check("after_rst_qvalid2", 64'(any_qv()), 64'd0);
      mem_rsp[2].p_valid        = 1'b1;
      mem_rsp[2].p.user.core_id = 8'd1;
      #2;
      check("drop_pvalid", 64'(core_rsp[1].p_valid), 64'd0);
      check("drop_ready", 64'(mem_rsp_ready[2]), 64'd1);
      cyc();
      mem_rsp[2].p_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cache_bank_interco.md
CACHE_BANK_INTERCO -- requirements
Module: cache_bank_interco

Interface
REQ-001 Parameter NumCore, default 4: number of core request ports; power of two, at least 2.
REQ-002 Parameter NumCache, default 4: number of cache banks; power of two, at least 2, at most NumCore.
REQ-003 Parameter AddrWidth, default 32: request address width.
REQ-004 Parameter ReqFifoDepth, default 2: per-core request FIFO depth, at least 1.
REQ-005 Parameter MaxOutstanding, default 4: per-core limit on requests issued but not yet answered, at least 1.
REQ-006 Parameters tcdm_req_t, tcdm_rsp_t, tcdm_req_chan_t, tcdm_rsp_chan_t: port and payload types; the response payload carries user.core_id.
REQ-007 Port clk_i, input, 1 bit: single clock, rising edge.
REQ-008 Port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-009 Port cfg_offset_i, input, $clog2(AddrWidth) bits: requested bank-select bit offset.
REQ-010 Port cfg_valid_i / cfg_ready_o, input / output, 1 bit each: offset reconfiguration handshake.
REQ-011 Port active_offset_o, output, $clog2(AddrWidth) bits: offset currently in use.
REQ-012 Port core_req_i / core_rsp_o, input / output, NumCore x tcdm_req_t / tcdm_rsp_t: core side.
REQ-013 Port core_rsp_ready_i, input, NumCore bits: core response back-pressure.
REQ-014 Port mem_req_o / mem_rsp_i, output / input, NumCache x tcdm_req_t / tcdm_rsp_t: bank side.
REQ-015 Port mem_rsp_ready_o, output, NumCache bits: bank response back-pressure.
REQ-016 Port perf_conflict_o, output, NumCache x 32 bits: per-bank conflict counters.

Function
REQ-017 Each core request is pushed into its own FIFO when q_valid and q_ready are both high; q_ready equals FIFO-not-full AND state RUN.
REQ-018 The bank index of a FIFO head is addr[active_offset +: log2(NumCache)].
REQ-019 Each bank has a round-robin arbiter over eligible heads; after a grant the pointer moves to the granted core plus 1, wrapping at NumCore.
REQ-020 A head is eligible only when the core's outstanding count is below MaxOutstanding.
REQ-021 A pop occurs when mem_req_o.q_valid and the bank q_ready are both high; minimum latency from core handshake to bank q_valid is 1 cycle.
REQ-022 The forwarded address has the log2(NumCache) bank bits at active_offset removed: bits above the field shift down and the top bits are zero.
REQ-023 Responses route to core user.core_id; per-core round-robin arbitration over banks; combinational pass-through, 0 cycles.
REQ-024 The outstanding count increments on a bank accept and decrements on a core response handshake; a simultaneous increment and decrement leaves it unchanged; it never exceeds MaxOutstanding.
REQ-025 FSM states: RUN, DRAIN, UPDATE.
REQ-026 RUN to DRAIN on cfg_valid_i, which blocks all core q_ready.
REQ-027 DRAIN to UPDATE when all FIFOs are empty and all outstanding counts are zero; a request that is already empty and idle moves through DRAIN in 1 cycle.
REQ-028 UPDATE latches cfg_offset_i into the active offset, asserts cfg_ready_o for exactly 1 cycle, then returns to RUN.
REQ-029 cfg_valid_i is held until cfg_ready_o; while not in RUN, changes to cfg_offset_i are ignored until UPDATE.
REQ-030 A conflict is a cycle in which more than one eligible head targets a bank; the bank counter saturates at 2^32-1.

Reset
REQ-031 rst_i clears FIFOs, outstanding counts, arbiter pointers (to 0), FSM (to RUN), the active offset (to 6), and counters; cfg_ready_o, all q_valid and all p_valid are 0 during reset and in the first cycle after.
REQ-032 Reset mid-operation discards in-flight requests; responses that arrive afterwards with no matching issued request are dropped with ready=1.

Configuration
REQ-033 With macro CACHE_BANK_INTERCO_PERF_EN defined, the conflict counters of REQ-030 are implemented.
REQ-034 Without CACHE_BANK_INTERCO_PERF_EN, perf_conflict_o is constant 0 and no counter flops exist; all other behaviour is identical.

Verification
REQ-035 NumCore=4, NumCache=4, offset 6; core0 reads 0x0000_0040 -> bank 1 q_valid one cycle later with addr 0x0000_0000; response with core_id=0 reaches core0 in the same cycle.
REQ-036 All 4 cores target bank 2 continuously, bank always ready -> grants 0,1,2,3,0 in order; with the macro defined, the bank-2 counter increments on every cycle in which at least 2 heads are eligible.
REQ-037 Bank 0 q_ready low and core1 issues 6 requests with ReqFifoDepth=2 and MaxOutstanding=4 -> core1 q_ready drops after 2 accepts.
REQ-038 Core0 has 3 requests outstanding and cfg_offset_i=12 with cfg_valid_i is applied -> q_ready is low until all 3 responses are delivered; cfg_ready_o pulses one cycle after the last response; address 0x1000 then maps to bank 1.
REQ-039 rst_i is asserted for 1 cycle while 2 requests are queued -> the FIFOs are empty, no mem q_valid occurs, and active_offset_o returns to 6.
